// File: rtl/dll_pkg.sv
// Shared data-link-layer types and widths for the LCRC transmit path.
package dll_pkg;
   localparam int TLP_W       = 208;
   localparam int LCRC_W      = 32;
   localparam int WORD_W      = 16;
   localparam int SEQ_W       = 12;
   localparam int FRAME_WORDS = 16;
   localparam int IDX_W       = $clog2(FRAME_WORDS);
   localparam int CNT_W       = 3;
   localparam int PAY_WORDS   = TLP_W / WORD_W;

   typedef enum logic [1:0] {
      IDLE,
      CRC_START,
      CRC_WAIT,
      SEND
   } fsm_state_t;
endpackage

// File: rtl/crc.sv
// 208-bit LCRC generator: CRC-32 (0x04C11DB7), MSB first, seed all-ones,
// complemented result, delivered LAT cycles after the enable strobe.
module crc
   import dll_pkg::*;
#(
   parameter int LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [TLP_W-1:0]  data,
   input  logic              enable,
   output logic [LCRC_W-1:0] crc_out
);

   localparam logic [LCRC_W-1:0] POLY = 32'h04C1_1DB7;

   function automatic logic [LCRC_W-1:0] lcrc_calc(input logic [TLP_W-1:0] d);
      logic [LCRC_W-1:0] c;
      logic              fb;
      c = '1;
      for (int i = TLP_W - 1; i >= 0; i--) begin
         fb = c[LCRC_W-1] ^ d[i];
         c  = {c[LCRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      end
      return ~c;
   endfunction

   logic [LCRC_W-1:0] pipe [LAT];

   // Stage 0 holds its value between strobes, so the tail stays valid afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) pipe[i] <= '0;
      end else begin
         if (enable) pipe[0] <= lcrc_calc(data);
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign crc_out = pipe[LAT-1];

endmodule

// File: rtl/frame_word_sel.sv
// Combinational frame word mux: header, 13 payload slices MSB first, 2 LCRC words.
module frame_word_sel
   import dll_pkg::*;
(
   input  logic [IDX_W-1:0]  idx,
   input  logic [SEQ_W-1:0]  seq,
   input  logic [TLP_W-1:0]  payload,
   input  logic [LCRC_W-1:0] lcrc,
   output logic [WORD_W-1:0] word
);

   int base;

   always_comb begin
      word = '0;
      base = TLP_W - 1;
      case (idx)
         IDX_W'(0):             word = {{(WORD_W-SEQ_W){1'b0}}, seq};
         IDX_W'(FRAME_WORDS-2): word = lcrc[LCRC_W-1 -: WORD_W];
         IDX_W'(FRAME_WORDS-1): word = lcrc[WORD_W-1:0];
         default: begin
            base = TLP_W - 1 - WORD_W * (int'(idx) - 1);
            word = payload[base -: WORD_W];
         end
      endcase
   end

endmodule

// File: rtl/lcrc_tx_framer.sv
// Data-link TX framer: latches a TLP, strobes the LCRC unit, then streams
// {seq header, 13 payload words, 2 LCRC words} with registered outputs.
module lcrc_tx_framer
   import dll_pkg::*;
#(
   parameter int               CRC_LAT  = 1,
   parameter logic [SEQ_W-1:0] SEQ_INIT = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [TLP_W-1:0]  tlp_data,
   input  logic              tlp_valid,
   output logic              tlp_ready,
   output logic [TLP_W-1:0]  crc_data,
   output logic              crc_en,
   input  logic [LCRC_W-1:0] crc_out,
   output logic [WORD_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sof,
   output logic              out_eof,
   output logic [SEQ_W-1:0]  seq_num
);

   fsm_state_t        state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [IDX_W-1:0]  idx, sel_idx;
   logic [LCRC_W-1:0] lcrc_q;
   logic [WORD_W-1:0] word_nxt;
   logic              accept, hs, last;

   assign accept = (state == IDLE) && tlp_valid && tlp_ready;
   assign hs     = out_valid && out_ready;
   assign last   = (idx == IDX_W'(FRAME_WORDS-1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (accept) state_nxt = CRC_START;
         CRC_START: state_nxt = CRC_WAIT;
         CRC_WAIT:  if (cnt == '0) state_nxt = SEND;
         SEND:      if (hs && last) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // The mux looks one word ahead so the output register loads the next word on each handshake.
   assign sel_idx = (state == CRC_WAIT) ? '0 : idx + IDX_W'(1);

   frame_word_sel u_sel (
      .idx     (sel_idx),
      .seq     (seq_num),
      .payload (crc_data),
      .lcrc    (lcrc_q),
      .word    (word_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tlp_ready <= 1'b1;
         crc_data  <= '0;
         crc_en    <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_eof   <= 1'b0;
         seq_num   <= SEQ_INIT;
         cnt       <= '0;
         idx       <= '0;
         lcrc_q    <= '0;
      end else begin
         tlp_ready <= (state_nxt == IDLE);
         crc_en    <= (state_nxt == CRC_START);
         case (state)
            IDLE: if (accept) crc_data <= tlp_data;
            CRC_START: cnt <= CNT_W'(CRC_LAT - 1);
            CRC_WAIT: begin
               if (cnt == '0) begin
                  lcrc_q    <= crc_out;
                  idx       <= '0;
                  out_data  <= word_nxt;
                  out_valid <= 1'b1;
                  out_sof   <= 1'b1;
                  out_eof   <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            SEND: begin
               if (hs) begin
                  if (last) begin
                     out_data  <= '0;
                     out_valid <= 1'b0;
                     out_sof   <= 1'b0;
                     out_eof   <= 1'b0;
                     seq_num   <= seq_num + SEQ_W'(1);
                  end else begin
                     idx      <= idx + IDX_W'(1);
                     out_data <= word_nxt;
                     out_sof  <= 1'b0;
                     out_eof  <= (idx == IDX_W'(FRAME_WORDS-2));
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lcrc_tx_framer.sv
// Directed bench: three framer+crc pairs (default, SEQ_INIT=FFE, CRC_LAT=3).
module tb_lcrc_tx_framer;
   import dll_pkg::*;

   localparam logic [207:0] P1 = 208'hABCD_FFFF_BBBB_FFFF_DDDD;
   localparam logic [207:0] P2 = 208'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000A_000B_000C_000D;
   localparam logic [207:0] P3 = 208'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000_FFFF;
   localparam logic [207:0] P4 = 208'h1357_9BDF_2468_ACE0_DEAD_BEEF_CAFE_F00D_0BAD_C0DE_8001_7FFE_5A5A;
   localparam logic [207:0] P5 = 208'hC001_D00D_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [207:0] td [3];
   logic [207:0] cd [3];
   logic [31:0]  co [3];
   logic [15:0]  od [3];
   logic [11:0]  sq [3];
   logic [2:0]   tv, tr, ce, ov, ordy, sof, eof;

   generate
      for (genvar g = 0; g < 3; g++) begin : g_inst
         localparam int          LAT = (g == 2) ? 3 : 1;
         localparam logic [11:0] SI  = (g == 1) ? 12'hFFE : 12'h000;
         lcrc_tx_framer #(.CRC_LAT(LAT), .SEQ_INIT(SI)) u_dut (
            .clk(clk), .rst(rst),
            .tlp_data(td[g]), .tlp_valid(tv[g]), .tlp_ready(tr[g]),
            .crc_data(cd[g]), .crc_en(ce[g]), .crc_out(co[g]),
            .out_data(od[g]), .out_valid(ov[g]), .out_ready(ordy[g]),
            .out_sof(sof[g]), .out_eof(eof[g]), .seq_num(sq[g])
         );
         crc #(.LAT(LAT)) u_crc (
            .clk(clk), .rst(rst), .data(cd[g]), .enable(ce[g]), .crc_out(co[g])
         );
      end
   endgenerate

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   int en_cnt [3] = '{default: 0};
   int en_cyc [3] = '{default: 0};
   always @(negedge clk)
      for (int k = 0; k < 3; k++)
         if (ce[k]) begin
            en_cnt[k] <= en_cnt[k] + 1;
            en_cyc[k] <= cyc;
         end

   function automatic logic [31:0] ref_crc(input logic [207:0] d);
      logic [31:0] c = 32'hFFFF_FFFF;
      for (int i = 207; i >= 0; i--) begin
         if (c[31] != d[i]) c = (c << 1) ^ 32'h04C1_1DB7;
         else               c = c << 1;
      end
      return ~c;
   endfunction

   function automatic logic [15:0] gw(input int i, input logic [11:0] s,
                                      input logic [207:0] pl, input logic [31:0] lc);
      logic [207:0] t;
      if (i == 0)  return {4'h0, s};
      if (i == 14) return lc[31:16];
      if (i == 15) return lc[15:0];
      t = pl >> (16 * (13 - i));
      return t[15:0];
   endfunction

   logic [15:0] got_w [16];

   // Offers one TLP on instance k and drains its frame; abort_at >= 0 returns
   // at the negedge where that word index is presented, without accepting it.
   task automatic run_frame(input int k, input logic [207:0] pl, input logic [11:0] seq,
                            input int lat, input int stall, input int abort_at, output int c0);
      int n, idx, en0;
      bit stalled, seen;
      logic [17:0] held;
      logic [31:0] lc;
      lc = ref_crc(pl);
      n = 0;
      while (!tr[k] && n < 100) begin @(negedge clk); n++; end
      chk($sformatf("k%0d_tlp_ready_wait", k), tr[k], 1);
      td[k] = pl; tv[k] = 1'b1; en0 = en_cnt[k];
      @(negedge clk);
      tv[k] = 1'b0; c0 = cyc;
      idx = 0; stalled = 0; seen = 0; n = 0; ordy[k] = 1'b0; held = '0;
      while (idx < 16 && n < 400) begin
         if (ov[k]) begin
            if (!seen) begin
               seen = 1;
               chk($sformatf("k%0d_w0_latency", k), cyc - c0, 1 + lat);
            end
            if (stalled) chk($sformatf("k%0d_stall_hold%0d", k, idx), {sof[k], eof[k], od[k]}, held);
            if (idx == abort_at) begin ordy[k] = 1'b0; return; end
            if (stall > 0 && $urandom_range(99) < stall) begin
               ordy[k] = 1'b0; stalled = 1; held = {sof[k], eof[k], od[k]};
            end else begin
               ordy[k] = 1'b1; stalled = 0; got_w[idx] = od[k];
               chk($sformatf("k%0d_word%0d", k, idx), od[k], gw(idx, seq, pl, lc));
               chk($sformatf("k%0d_sof%0d", k, idx), sof[k], idx == 0);
               chk($sformatf("k%0d_eof%0d", k, idx), eof[k], idx == 15);
               chk($sformatf("k%0d_busy%0d", k, idx), tr[k], 0);
               idx++;
            end
         end
         if (idx < 16) begin @(negedge clk); n++; end
      end
      chk($sformatf("k%0d_frame_done", k), idx, 16);
      @(negedge clk);
      ordy[k] = 1'b0;
      chk($sformatf("k%0d_ready_back", k), tr[k], 1);
      chk($sformatf("k%0d_valid_drop", k), ov[k], 0);
      chk($sformatf("k%0d_crc_en_pulses", k), en_cnt[k] - en0, 1);
      chk($sformatf("k%0d_crc_en_cycle", k), en_cyc[k], c0);
   endtask

   initial begin
      int c, c1, c2;
      tv = '0; ordy = '0;
      for (int k = 0; k < 3; k++) td[k] = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_tlp_ready", tr, 3'b111);
      chk("rst_out_valid", ov, 0);
      chk("rst_sof_eof", {sof, eof}, 0);
      chk("rst_crc_en", ce, 0);
      chk("rst_out_data", od[0], 0);
      chk("rst_crc_data", cd[0], 0);
      chk("rst_seq0", sq[0], 12'h000);
      chk("rst_seq1", sq[1], 12'hFFE);

      // single frame, hand-derived payload slices
      run_frame(0, P1, 12'h000, 1, 0, -1, c);
      chk("p1_hdr", got_w[0], 16'h0000);
      chk("p1_w1", got_w[1], 16'h0000);
      chk("p1_w8", got_w[8], 16'h0000);
      chk("p1_w9", got_w[9], 16'hABCD);
      chk("p1_w10", got_w[10], 16'hFFFF);
      chk("p1_w11", got_w[11], 16'hBBBB);
      chk("p1_w12", got_w[12], 16'hFFFF);
      chk("p1_w13", got_w[13], 16'hDDDD);
      chk("p1_seq_after", sq[0], 12'h001);

      // back-to-back frames, throughput 19 cycles at CRC_LAT=1
      run_frame(0, P2, 12'h001, 1, 0, -1, c1);
      chk("b2b_period1", c1 - c, 19);
      run_frame(0, P3, 12'h002, 1, 0, -1, c2);
      chk("b2b_period2", c2 - c1, 19);

      // random back-pressure
      run_frame(0, P4, 12'h003, 1, 30, -1, c);
      run_frame(0, P5, 12'h004, 1, 30, -1, c);

      // sequence wrap
      run_frame(1, P2, 12'hFFE, 1, 0, -1, c);
      run_frame(1, P4, 12'hFFF, 1, 0, -1, c);
      run_frame(1, P1, 12'h000, 1, 0, -1, c);
      chk("wrap_seq_after", sq[1], 12'h001);

      // longer CRC latency
      run_frame(2, P4, 12'h000, 3, 0, -1, c);
      run_frame(2, P1, 12'h001, 3, 20, -1, c);

      // reset during word 7
      run_frame(0, P3, 12'h005, 1, 0, 7, c);
      chk("pre_rst_valid", ov[0], 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", ov[0], 0);
      chk("mid_rst_data", od[0], 0);
      chk("mid_rst_sof_eof", {sof[0], eof[0]}, 0);
      chk("mid_rst_seq", sq[0], 12'h000);
      chk("mid_rst_seq1", sq[1], 12'hFFE);
      chk("mid_rst_crc_data", cd[0], 0);
      chk("mid_rst_ready", tr[0], 1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_frame(0, P5, 12'h000, 1, 0, -1, c);
      chk("post_rst_seq", sq[0], 12'h001);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout got=%0d exp=0", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/lcrc_tx_framer.md
# lcrc_tx_framer

Data-link transmit framer that sits directly downstream of the 208-bit LCRC generator (`crc`). It accepts one 208-bit TLP payload per handshake, holds it on the CRC unit's data input, pulses `crc_en`, captures the 32-bit LCRC, and emits the frame as sixteen 16-bit words: a sequence-number header, 13 payload words, then 2 LCRC words. It owns the 12-bit transmit sequence counter and feeds the physical-layer serializer through a valid/ready stream.

## Interface
- `CRC_LAT`, default 1: cycles from the `crc_en` pulse to a valid `crc_out` (range 1–7).
- `SEQ_INIT`, default 12'h000: sequence number after reset.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `tlp_data`  in  208  payload, MSB first
- `tlp_valid`  in  1  payload offered
- `tlp_ready`  out  1  framer can accept
- `crc_data`  out  208  payload to the CRC unit, held stable for the whole frame
- `crc_en`  out  1  one-cycle CRC compute strobe
- `crc_out`  in  32  LCRC returned by the CRC unit
- `out_data`  out  16  frame word
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  downstream accepts
- `out_sof`  out  1  first word of frame
- `out_eof`  out  1  last word of frame
- `seq_num`  out  12  sequence number of the current or next frame

## Operation
- FSM states: IDLE, CRC_START, CRC_WAIT, SEND.
- IDLE:
  - `tlp_ready`=1.
  - When `tlp_valid` and `tlp_ready` are both high, latch `tlp_data` into `crc_data` and go to CRC_START.
- CRC_START:
  - `crc_en`=1 for exactly this cycle.
  - Load the wait counter with `CRC_LAT`-1, then go to CRC_WAIT.
- CRC_WAIT:
  - Decrement the counter.
  - When the counter is 0, capture `crc_out` into the LCRC register, clear the word index, and go to SEND.
- SEND:
  - `out_valid`=1. The word index advances only when `out_valid` and `out_ready` are both high.
  - Word 0 is {4'h0, `seq_num`}.
  - Words 1–13 are `crc_data`[207:192] down to [15:0].
  - Word 14 is LCRC[31:16]; word 15 is LCRC[15:0].
  - `out_sof`=1 at word 0; `out_eof`=1 at word 15.
  - When word 15 is accepted: `seq_num` increments modulo 4096 (4095 wraps to 0), then go to IDLE.
- `out_data`, `out_sof` and `out_eof` hold stable while `out_valid` is high and `out_ready` is low.
- `crc_en` is 0 outside CRC_START. `tlp_ready` is 0 outside IDLE, so there is no overlap between frames.
- Reset asserted at any point, including mid-frame:
  - Immediately forces IDLE.
  - The partial frame is discarded, with no `out_eof`.
  - `seq_num` returns to `SEQ_INIT`.

## Timing
- Reset values:
  - `tlp_ready`=1 after reset release; all other outputs are 0.
  - `crc_data`=0, `seq_num`=`SEQ_INIT`, FSM in IDLE.
- Accept at cycle T: `crc_en` high at T+1; LCRC captured at T+1+`CRC_LAT`; word 0 valid at T+2+`CRC_LAT`.
- With `out_ready` held high, `out_eof` is at T+17+`CRC_LAT`, and `tlp_ready` is back at T+18+`CRC_LAT`.
- Throughput is 1 frame per 18+`CRC_LAT` cycles.
- Back-pressure: each low cycle of `out_ready` stretches the frame by one cycle. No word is dropped or duplicated.
- All outputs are registered. There is no combinational path from `out_ready` to `out_data`.

## Structure
- Shared package `dll_pkg` holds:
  - the FSM state enum;
  - `TLP_W`=208, `LCRC_W`=32, `WORD_W`=16, `SEQ_W`=12, `FRAME_WORDS`=16.
- Word mux is a natural sub-module: `frame_word_sel`, combinational, mapping index + seq + payload + LCRC to a 16-bit word. It is registered in the parent.
- The bench instantiates the real `crc` alongside the framer, wired `crc_data`→data, `crc_en`→enable, and `crc_out`→`crc_out`.

## Test plan
- Reset, then a single payload of 208'hABCD_FFFF_BBBB_FFFF_DDDD with `out_ready`=1 → 16 words:
  - word 0 = 16'h0000;
  - words 1–13 = payload slices;
  - words 14–15 = `crc` reference output;
  - `out_sof` and `out_eof` on words 0 and 15;
  - `crc_en` high exactly one cycle.
- Three back-to-back frames → headers 0x0000, 0x0001, 0x0002, and `tlp_ready` low throughout each frame.
- Random `out_ready` stalls (30% low) → every word matches the golden frame, and `out_data` is stable during stalls.
- `SEQ_INIT`=12'hFFE, three frames → headers 0x0FFE, 0x0FFF, 0x0000.
- `rst` pulsed during word 7 → outputs cleared within the same cycle, `seq_num` restored, and the next frame starts cleanly with `out_sof`.
- `CRC_LAT`=3 → word 0 appears at T+5, and LCRC words match the reference.
